regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback sources: the ALU and the memory load unit. Each source uses a valid/ready handshake. Ties are broken round-robin, and the winner is driven onto a registered wr_addr/wr_enable/wr_data stage that connects directly to the register file. An integrated pending-write scoreboard marks reserved destination registers so issue logic can stall on read-after-write hazards.

Parameters:
DATA_BITS, REGISTER_DATA_BITS (constants_pkg), width of write data.
NUM_REGS, 16, number of architectural registers; fixed to match the 4-bit register address.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
alu_valid  input  1  ALU writeback request
alu_addr  input  4  ALU destination register
alu_data  input  DATA_BITS  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_addr  input  4  load destination register
mem_data  input  DATA_BITS  load data
mem_ready  output  1  load request accepted this cycle
reserve_valid  input  1  issue logic marks a destination as pending
reserve_addr  input  4  register to mark pending
rd0_addr  input  4  hazard lookup address 0
rd0_pending  output  1  rd0_addr has an outstanding write
rd1_addr  input  4  hazard lookup address 1
rd1_pending  output  1  rd1_addr has an outstanding write
wr_addr  output  4  to register file wr_addr
wr_enable  output  1  to register file wr_enable
wr_data  output  DATA_BITS  to register file wr_data

Behaviour:
- Reset values:
  - wr_enable=0, wr_addr=0, wr_data=0.
  - pending[15:0]=0.
  - last_grant=REQ_MEM, so the ALU wins the first tie.
  - ready outputs follow the combinational rules below.
- Reset is synchronous. Reset mid-operation drops any in-flight write: wr_enable is 0 in the cycle after reset, and all pending bits clear.
- Arbitration is combinational in cycle N:
  - Only alu_valid: alu_ready=1.
  - Only mem_valid: mem_ready=1.
  - Both valid: grant goes to the requester that is not last_grant.
  - At most one ready is high per cycle.
  - Ready never depends on ready. Valid must not depend on ready.
- Handshake: a transfer occurs when valid&&ready at a rising edge. A requester holds valid, addr and data stable until accepted.
- Output stage:
  - An accepted request in cycle N produces wr_enable=1, wr_addr and wr_data in cycle N+1.
  - The register file captures it at the end of N+1, so the data is readable in N+2.
  - With no transfer in cycle N, wr_enable=0 in N+1; wr_addr and wr_data hold their previous values.
  - The register file never backpressures, so the output stage always accepts. Throughput is one write per cycle.
- last_grant updates only on a transfer, to the requester that transferred.
- Same destination from both requesters: no merge. The writes serialize in grant order, and the later one wins in the register file.
- Scoreboard:
  - At each rising edge, pending[reserve_addr] is set if reserve_valid.
  - At each rising edge, pending[wr_addr] is cleared if wr_enable.
  - Set and clear on the same address in the same edge: set wins, because a new reservation supersedes the completing write.
  - A write to an unreserved register is legal; its clear is a no-op.
  - Reserving an already-pending register leaves it pending. There is no counting; issue logic must not reserve twice before completion.
- Lookup: rdX_pending = pending[rdX_addr], purely combinational from the registered vector. There is no bypass from the current-cycle reserve or write.
- Timing: pending clears in cycle N+2 relative to acceptance in N, the same cycle the data becomes readable, so no stale read is possible.

Decomposition:
- constants_pkg additions:
  - typedef reg_addr_t = logic [3:0].
  - enum requester_t {REQ_ALU=0, REQ_MEM=1}.
  - NUM_REGS=16.
- Sub-module regfile_scoreboard: a 16-bit pending vector with set/clear ports, set-priority, and two combinational lookup ports.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset, then alu_valid=1, addr=3, data=0x5A in cycle 1 -> alu_ready=1 in cycle 1; wr_enable=1, wr_addr=3, wr_data=0x5A in cycle 2; wr_enable=0 in cycle 3.
- Both valid every cycle for 4 cycles (ALU addr 1, MEM addr 2) -> grants alternate ALU, MEM, ALU, MEM; wr_addr sequence 1,2,1,2 with wr_enable continuously 1.
- reserve_valid, reserve_addr=7 at cycle 0 -> rd0_pending=1 with rd0_addr=7 from cycle 1; MEM writes addr 7 accepted at cycle 3 -> rd0_pending stays 1 in cycle 4, becomes 0 in cycle 5.
- Completing write to addr 4 (wr_enable=1, wr_addr=4) coincides with reserve_addr=4 -> pending[4] remains 1 afterwards.
- Accept an ALU request in cycle N, then assert reset in cycle N+1 with a reserved register 9 -> after reset wr_enable=0, rd1_pending(9)=0, and the first tie goes to the ALU.
- mem_valid held 3 cycles while the ALU wins a tie -> mem_addr and mem_data are sampled only in the accepted cycle; exactly one write per accepted handshake, none duplicated.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared register-file constants and types for the writeback path.
package constants_pkg;

    localparam int REGISTER_DATA_BITS = 32;
    localparam int NUM_REGS           = 16;

    typedef logic [3:0] reg_addr_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } requester_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set by issue
// reservations, cleared by completing writes, with two combinational lookups.
module regfile_scoreboard
    import constants_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_valid,
    input  reg_addr_t set_addr,
    input  logic      clr_valid,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rd0_addr,
    output logic      rd0_pending,
    input  reg_addr_t rd1_addr,
    output logic      rd1_pending
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    // Next pending vector: apply the clear first so a same-address set overrides it.
    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
        pending_next = pending;
        if (clr_valid) begin
            pending_next[clr_addr] = 1'b0;
        end
        if (set_valid) begin
            pending_next[set_addr] = 1'b1;
        end
    end

    // Pending register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: this vector is reset (unlike a data RAM) because a stale
        // reservation surviving reset would stall issue indefinitely.
        if (reset) begin
            pending <= '0;
        end else begin
            // NOTE: non-blocking assignment for state so all flops update together at the edge.
            pending <= pending_next;
        end
    end

    // Hazard lookups read only the registered vector; no same-cycle bypass.
    assign rd0_pending = pending[rd0_addr];
    assign rd1_pending = pending[rd1_addr];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load unit, with a registered write stage and pending-write scoreboard.
module regfile_write_arbiter
    import constants_pkg::*;
#(
    parameter int DATA_BITS = REGISTER_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  reg_addr_t            alu_addr,
    input  logic [DATA_BITS-1:0] alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  reg_addr_t            mem_addr,
    input  logic [DATA_BITS-1:0] mem_data,
    output logic                 mem_ready,
    input  logic                 reserve_valid,
    input  reg_addr_t            reserve_addr,
    input  reg_addr_t            rd0_addr,
    output logic                 rd0_pending,
    input  reg_addr_t            rd1_addr,
    output logic                 rd1_pending,
    output reg_addr_t            wr_addr,
    output logic                 wr_enable,
    output logic [DATA_BITS-1:0] wr_data
);

    requester_t last_grant;

    // Grant: a lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (alu_valid && mem_valid) begin
            alu_ready = (last_grant == REQ_MEM);
            mem_ready = (last_grant == REQ_ALU);
        end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid;
        end
    end

    // Round-robin pointer moves only when a transfer actually happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_MEM;
        end else if (alu_ready) begin
            last_grant <= REQ_ALU;
        end else if (mem_ready) begin
            last_grant <= REQ_MEM;
        end
    end

    // Registered write stage; address and data hold when no transfer occurs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_enable <= alu_ready || mem_ready;
            if (alu_ready) begin
                wr_addr <= alu_addr;
                wr_data <= alu_data;
            end else if (mem_ready) begin
                wr_addr <= mem_addr;
                wr_data <= mem_data;
            end
        end
    end

    // The write being presented to the register file retires its reservation.
    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_valid   (reserve_valid),
        .set_addr    (reserve_addr),
        .clr_valid   (wr_enable),
        .clr_addr    (wr_addr),
        .rd0_addr    (rd0_addr),
        .rd0_pending (rd0_pending),
        .rd1_addr    (rd1_addr),
        .rd1_pending (rd1_pending)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_regfile_write_arbiter;
    import constants_pkg::*;

    localparam int DW = REGISTER_DATA_BITS;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, mem_valid, reserve_valid;
    reg_addr_t       alu_addr, mem_addr, reserve_addr, rd0_addr, rd1_addr;
    logic [DW-1:0]   alu_data, mem_data;
    logic            alu_ready, mem_ready, rd0_pending, rd1_pending, wr_enable;
    reg_addr_t       wr_addr;
    logic [DW-1:0]   wr_data;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit            m_pending [NUM_REGS];
    int            m_last;          // 0 = ALU granted last, 1 = MEM granted last
    bit            m_wr_en;
    reg_addr_t     m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit            m_alu_acc, m_mem_acc;
    int            m_writes = 0;
    int            dut_writes = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .rd0_addr      (rd0_addr),
        .rd0_pending   (rd0_pending),
        .rd1_addr      (rd1_addr),
        .rd1_pending   (rd1_pending),
        .wr_addr       (wr_addr),
        .wr_enable     (wr_enable),
        .wr_data       (wr_data)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Who wins this cycle: bit0 = ALU, bit1 = MEM.
    function automatic logic [1:0] winner(input logic av, input logic mv, input int last);
        if (av && mv) return (last == 0) ? 2'b10 : 2'b01;
        return {mv, av};
    endfunction

    // Model advance at each rising edge, from the inputs present during the cycle.
    task automatic model_step();
        logic [1:0] w;
        if (reset) begin
            foreach (m_pending[i]) m_pending[i] = 1'b0;
            m_last = 1; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
            m_alu_acc = 1'b0; m_mem_acc = 1'b0;
        end else begin
            w = winner(alu_valid, mem_valid, m_last);
            if (m_wr_en) m_pending[m_wr_addr] = 1'b0;
            if (reserve_valid) m_pending[reserve_addr] = 1'b1;
            m_alu_acc = w[0];
            m_mem_acc = w[1];
            m_wr_en   = (w != 2'b00);
            if (w[0]) begin
                m_wr_addr = alu_addr; m_wr_data = alu_data; m_last = 0;
            end else if (w[1]) begin
                m_wr_addr = mem_addr; m_wr_data = mem_data; m_last = 1;
            end
            if (m_wr_en) m_writes++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] w;
        if (chk_en) begin
            w = winner(alu_valid, mem_valid, m_last);
            check("alu_ready",   {31'b0, alu_ready},   {31'b0, w[0]});
            check("mem_ready",   {31'b0, mem_ready},   {31'b0, w[1]});
            check("wr_enable",   {31'b0, wr_enable},   {31'b0, m_wr_en});
            check("wr_addr",     {28'b0, wr_addr},     {28'b0, m_wr_addr});
            check("wr_data",     wr_data,              m_wr_data);
            check("rd0_pending", {31'b0, rd0_pending}, {31'b0, m_pending[rd0_addr]});
            check("rd1_pending", {31'b0, rd1_pending}, {31'b0, m_pending[rd1_addr]});
            if (wr_enable === 1'b1) dut_writes++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        reserve_valid = 1'b0; reserve_addr = '0;
        rd0_addr = '0; rd1_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_seq [4];
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 1; exp_seq[3] = 2;

        idle_inputs();
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset values
        at_neg();
        check("rst_wr_enable", {31'b0, wr_enable}, 32'd0);
        check("rst_wr_addr",   {28'b0, wr_addr},   32'd0);
        check("rst_wr_data",   wr_data,            32'd0);
        check("rst_pending",   {31'b0, rd0_pending}, 32'd0);

        // Single ALU write: ready in cycle 1, write in cycle 2, idle in cycle 3
        tick();
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h5A;
        at_neg();
        check("t1_alu_ready", {31'b0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        at_neg();
        check("t1_wr_enable", {31'b0, wr_enable}, 32'd1);
        check("t1_wr_addr",   {28'b0, wr_addr},   32'd3);
        check("t1_wr_data",   wr_data,            32'h5A);
        tick();
        at_neg();
        check("t1_wr_idle",   {31'b0, wr_enable}, 32'd0);

        // Continuous tie: grants alternate ALU, MEM, ALU, MEM
        do_reset();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_valid = 1'b0;
            at_neg();
            check("rr_wr_enable", {31'b0, wr_enable}, 32'd1);
            check("rr_wr_addr",   {28'b0, wr_addr},   exp_seq[i]);
        end
        tick();
        alu_valid = 1'b0;

        // Reservation of r7 clears two cycles after the load is accepted
        do_reset();
        reserve_valid = 1'b1; reserve_addr = 4'd7; rd0_addr = 4'd7;
        tick();
        reserve_valid = 1'b0;
        at_neg();
        check("sb_c1", {31'b0, rd0_pending}, 32'd1);
        tick();
        at_neg();
        check("sb_c2", {31'b0, rd0_pending}, 32'd1);
        tick();
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h77;
        at_neg();
        check("sb_c3_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("sb_c3", {31'b0, rd0_pending}, 32'd1);
        tick();
        mem_valid = 1'b0;
        at_neg();
        check("sb_c4_wr_enable", {31'b0, wr_enable}, 32'd1);
        check("sb_c4", {31'b0, rd0_pending}, 32'd1);
        tick();
        at_neg();
        check("sb_c5", {31'b0, rd0_pending}, 32'd0);

        // Set wins over a coinciding clear on r4
        do_reset();
        reserve_valid = 1'b1; reserve_addr = 4'd4;
        tick();
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 32'h44;
        tick();
        alu_valid = 1'b0;
        reserve_valid = 1'b1; reserve_addr = 4'd4;
        at_neg();
        check("sw_wr_addr", {28'b0, wr_addr}, 32'd4);
        tick();
        reserve_valid = 1'b0; rd1_addr = 4'd4;
        at_neg();
        check("sw_pending", {31'b0, rd1_pending}, 32'd1);
        tick();
        at_neg();
        check("sw_pending_hold", {31'b0, rd1_pending}, 32'd1);

        // Reset after an accepted write, with r9 reserved
        do_reset();
        reserve_valid = 1'b1; reserve_addr = 4'd9;
        tick();
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd1_addr = 4'd9;
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h55;
        mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 32'h66;
        at_neg();
        check("mr_wr_enable", {31'b0, wr_enable},   32'd0);
        check("mr_pending9",  {31'b0, rd1_pending}, 32'd0);
        check("mr_tie_alu",   {31'b0, alu_ready},   32'd1);
        check("mr_tie_mem",   {31'b0, mem_ready},   32'd0);

        // Held load waits out the ALU win, then writes exactly once
        tick();
        alu_valid = 1'b0;
        at_neg();
        check("hold_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("hold_wr_addr",   {28'b0, wr_addr},   32'd5);
        tick();
        mem_valid = 1'b0; mem_data = 32'hDEAD;
        at_neg();
        check("hold_wr_enable", {31'b0, wr_enable}, 32'd1);
        check("hold_wr_addr2",  {28'b0, wr_addr},   32'd6);
        check("hold_wr_data",   wr_data,            32'h66);
        tick();
        at_neg();
        check("hold_no_dup",    {31'b0, wr_enable}, 32'd0);

        // Randomized traffic obeying the hold-until-accepted rule
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 99) == 0);
            if (!alu_valid || m_alu_acc) begin
                alu_valid = $urandom_range(0, 1);
                alu_addr  = reg_addr_t'($urandom_range(0, 15));
                alu_data  = $urandom;
            end
            if (!mem_valid || m_mem_acc) begin
                mem_valid = $urandom_range(0, 1);
                mem_addr  = reg_addr_t'($urandom_range(0, 15));
                mem_data  = $urandom;
            end
            reserve_valid = ($urandom_range(0, 3) == 0);
            reserve_addr  = reg_addr_t'($urandom_range(0, 15));
            rd0_addr      = reg_addr_t'($urandom_range(0, 15));
            rd1_addr      = reg_addr_t'($urandom_range(0, 15));
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        at_neg();
        check("write_count", dut_writes, m_writes);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
